// File: rtl/neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : neuron_scheduler
// Purpose  : Shares one leaky integrate-and-fire datapath across N_NEURONS
//            virtual neurons and publishes a spike vector per timestep.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_scheduler #(
    parameter int                N_NEURONS = 8,
    parameter logic signed [7:0] THRESHOLD = 8'sd102,
    parameter int                REFRACT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step_start,
    input  logic                         in_valid,
    input  logic signed [7:0]            in_data,
    output logic                         in_ready,
    output logic [$clog2(N_NEURONS)-1:0] idx,
    output logic                         busy,
    output logic                         step_done,
    output logic [N_NEURONS-1:0]         spk_vec
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] c_last    = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0] c_one     = IDX_W'(1);
    localparam logic [3:0]       c_refract = 4'(REFRACT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [N_NEURONS-1:0]   r_acc;
    logic [N_NEURONS-1:0]   r_spk;
    logic signed [7:0]      r_mem  [N_NEURONS];
    logic [3:0]             r_refr [N_NEURONS];

    logic signed [7:0]      w_v;
    logic signed [7:0]      w_decay;
    logic signed [8:0]      w_sum9;
    logic signed [7:0]      w_sat;
    logic                   w_refr_active;
    logic                   w_fire;
    logic                   w_hs;
    logic [N_NEURONS-1:0]   w_acc_next;

    // Decay keeps 3/4 of the membrane potential; shifts stay arithmetic.
    always_comb begin
        w_v           = r_mem[r_idx];
        w_decay       = (w_v >>> 1) + (w_v >>> 2);
        w_sum9        = {w_decay[7], w_decay} + {in_data[7], in_data};
        if (w_sum9[8] != w_sum9[7]) begin
            w_sat = w_sum9[8] ? 8'sh80 : 8'sh7f;
        end else begin
            w_sat = w_sum9[7:0];
        end
        w_refr_active = (r_refr[r_idx] != 4'd0);
        w_fire        = !w_refr_active && (w_sat >= THRESHOLD);
        w_hs          = in_valid && (r_state == S_RUN);
        w_acc_next         = r_acc;
        w_acc_next[r_idx]  = w_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_spk   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_mem[i]  <= '0;
                r_refr[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (step_start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        if (w_refr_active) begin
                            // Refractory neurons discard their input entirely.
                            r_mem[r_idx]  <= '0;
                            r_refr[r_idx] <= r_refr[r_idx] - 4'd1;
                        end else if (w_fire) begin
                            r_mem[r_idx]  <= w_sat - THRESHOLD;
                            r_refr[r_idx] <= c_refract;
                        end else begin
                            r_mem[r_idx]  <= w_sat;
                        end
                        r_acc <= w_acc_next;
                        if (r_idx == c_last) begin
                            r_spk   <= w_acc_next;
                            r_idx   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + c_one;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign step_done = (r_state == S_DONE);
    assign idx       = r_idx;
    assign spk_vec   = r_spk;

endmodule
`default_nettype wire

// File: tb/tb_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_scheduler
// Purpose  : Self-checking bench for neuron_scheduler (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_scheduler;

    localparam int N    = 8;
    localparam int TH   = 102;
    localparam int REFR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              step_start = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_data = 8'sd0;
    logic              in_ready;
    logic [2:0]        idx;
    logic              busy;
    logic              step_done;
    logic [N-1:0]      spk_vec;

    neuron_scheduler #(
        .N_NEURONS (N),
        .THRESHOLD (8'sd102),
        .REFRACT   (REFR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_start (step_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .idx        (idx),
        .busy       (busy),
        .step_done  (step_done),
        .spk_vec    (spk_vec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][7:0]   cur;
        logic [7:0]        spk;
        logic signed [7:0] mem0;
        logic signed [7:0] mem3;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  sbq[$];
    logic [7:0]  mon_exp;
    int          mm [N];
    int          mr [N];
    vec_t        tbl [7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard sink: every step_done pulse consumes one expected vector.
    always @(posedge clk) begin
        #1;
        if (step_done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_step_done: got spk_vec %0h, expected no pulse", spk_vec);
            end else begin
                mon_exp = sbq.pop_front();
                check("spk_vec", int'(spk_vec), int'(mon_exp));
            end
        end
    end

    task automatic model_clear();
        for (int j = 0; j < N; j++) begin
            mm[j] = 0;
            mr[j] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0][7:0] cur, output logic [7:0] spk);
        int v, d, s;
        spk = '0;
        for (int k = 0; k < N; k++) begin
            v = mm[k];
            d = (v >>> 1) + (v >>> 2);
            s = d + int'($signed(cur[k]));
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
            if (mr[k] != 0) begin
                mm[k] = 0;
                mr[k] = mr[k] - 1;
            end else if (s >= TH) begin
                spk[k] = 1'b1;
                mm[k]  = s - TH;
                mr[k]  = REFR;
            end else begin
                mm[k] = s;
            end
        end
    endtask

    task automatic check_state_vs_model();
        int bad;
        bad = 0;
        for (int j = 0; j < N; j++) begin
            if (int'($signed(dut.r_mem[j])) != mm[j] || int'(dut.r_refr[j]) != mr[j]) bad++;
        end
        check("state_vs_model", bad, 0);
    endtask

    task automatic run_step(input logic [7:0][7:0] cur, input bit gaps, input bit extra,
                            input bit use_tbl, input logic [7:0] tbl_spk);
        logic [7:0] mspk;
        int         k, cyc, edges;
        bit         hs;
        model_step(cur, mspk);
        sbq.push_back(use_tbl ? tbl_spk : mspk);
        @(negedge clk);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        edges = 1;
        check("busy_after_start", int'(busy), 1);
        k = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            check("idx", int'(idx), k);
            check("no_done_in_run", int'(step_done), 0);
            in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data    = $signed(cur[k]);
            step_start = extra && (k == 2);
            hs         = in_valid && in_ready;
            @(posedge clk);
            edges++;
            cyc++;
            if (hs) k++;
            @(negedge clk);
        end
        step_start = 1'b0;
        if (k < N) check("step_timeout", k, N);
        check("step_done_pulse", int'(step_done), 1);
        check("in_ready_done", int'(in_ready), 0);
        if (!gaps) check("done_latency", edges, N + 1);
        check_state_vs_model();
        // Valid data offered in DONE and IDLE must be ignored.
        in_valid = 1'b1;
        in_data  = 8'sh7f;
        @(negedge clk);
        check("step_done_width", int'(step_done), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic abort_step(input int n);
        int k, cyc, bad;
        bit hs;
        @(negedge clk);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < n && cyc < 50) begin
            in_valid = 1'b1;
            in_data  = 8'sd110;
            hs       = in_ready;
            @(posedge clk);
            cyc++;
            if (hs) k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (k < n) check("abort_timeout", k, n);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_spk_vec", int'(spk_vec), 0);
        check("rst_idx", int'(idx), 0);
        bad = 0;
        for (int j = 0; j < N; j++) begin
            if (dut.r_mem[j] != 8'sd0 || dut.r_refr[j] != 4'd0) bad++;
        end
        check("rst_state_cleared", bad, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][7:0] cur;

        for (int s = 0; s < 7; s++) tbl[s] = '0;
        tbl[0].cur[0] = 8'd40;  tbl[0].cur[3] = 8'h80; tbl[0].cur[5] = 8'd110;
        tbl[0].spk = 8'h20; tbl[0].mem0 = 8'sd40; tbl[0].mem3 = 8'sh80;
        tbl[1].cur[0] = 8'd40;  tbl[1].cur[3] = 8'h80; tbl[1].cur[1] = 8'd127;
        tbl[1].spk = 8'h02; tbl[1].mem0 = 8'sd70; tbl[1].mem3 = 8'sh80;
        tbl[2].cur[0] = 8'd40;  tbl[2].cur[6] = 8'd101; tbl[2].cur[7] = 8'd102;
        tbl[2].spk = 8'h80; tbl[2].mem0 = 8'sd92; tbl[2].mem3 = 8'shA0;
        tbl[3].cur[0] = 8'd40;
        tbl[3].spk = 8'h01; tbl[3].mem0 = 8'sd7;  tbl[3].mem3 = 8'shB8;
        tbl[4].cur[0] = 8'd127;
        tbl[4].spk = 8'h00; tbl[4].mem0 = 8'sd0;  tbl[4].mem3 = 8'shCA;
        tbl[5].cur[0] = 8'd127;
        tbl[5].spk = 8'h00; tbl[5].mem0 = 8'sd0;  tbl[5].mem3 = 8'shD7;
        tbl[6].cur[0] = 8'd127;
        tbl[6].spk = 8'h01; tbl[6].mem0 = 8'sd25; tbl[6].mem3 = 8'shE0;

        model_clear();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_spk_vec", int'(spk_vec), 0);
        rst = 1'b0;

        // Mid-step asynchronous reset, then an all-zero step.
        abort_step(2);
        run_step('0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Integration, firing, refractory and saturation sequence.
        for (int s = 0; s < 7; s++) begin
            run_step(tbl[s].cur, 1'b0, 1'b0, 1'b1, tbl[s].spk);
            check("mem0", int'($signed(dut.r_mem[0])), int'(tbl[s].mem0));
            check("mem3", int'($signed(dut.r_mem[3])), int'(tbl[s].mem3));
        end

        // Random currents with in_valid gaps and stray step_start pulses.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < N; k++) cur[k] = 8'($urandom_range(0, 255));
            run_step(cur, 1'b1, 1'b1, 1'b0, 8'h00);
        end

        // Reset during step 4 of a neuron-0 integration run.
        abort_step(0);
        cur = '0;
        cur[0] = 8'd40;
        run_step(cur, 1'b0, 1'b0, 1'b0, 8'h00);
        run_step(cur, 1'b0, 1'b0, 1'b0, 8'h00);
        cur[2] = 8'd120;
        run_step(cur, 1'b0, 1'b0, 1'b0, 8'h00);
        check("spk_before_abort", int'(spk_vec), 32'h04);
        abort_step(3);
        cur = '0;
        cur[0] = 8'd40;
        run_step(cur, 1'b0, 1'b0, 1'b0, 8'h00);
        check("restart_mem0", int'($signed(dut.r_mem[0])), 40);

        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neuron_scheduler.md
# neuron_scheduler

Time-multiplexed controller that shares one leaky integrate-and-fire update datapath among `N_NEURONS` virtual neurons. It owns the membrane-potential and refractory state for every neuron. On each timestep it sequences one input current per neuron through decay, integrate, threshold and subtractive-reset, then publishes the timestep's spike vector. It sits between the MAC/synapse stage, which supplies per-neuron currents in index order, and the downstream spike consumer.

## Interface

Parameters:
- `N_NEURONS`, 8: number of virtual neurons, ≥2.
- `THRESHOLD`, 8'sd102: firing threshold, signed Q1.7 (≈0.8).
- `REFRACT`, 2: refractory length in timesteps, 0–15.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `step_start` input 1: one-cycle pulse that begins a timestep.
- `in_valid` input 1: `in_data` carries the current for neuron `idx`.
- `in_data` input 8: signed input current, Q1.7.
- `in_ready` output 1: the block accepts a current this cycle.
- `idx` output clog2(N): neuron index expected next.
- `busy` output 1: a timestep is in progress.
- `step_done` output 1: one-cycle pulse marking the end of a timestep.
- `spk_vec` output N: spike bit per neuron for the last completed timestep.

## Operation

- State is held in two per-neuron arrays: `mem[N]`, signed 8-bit, and `refr[N]`, 4-bit.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on `step_start`. `idx` is set to 0 and the spike accumulator is cleared.
  - RUN → DONE on the handshake for `idx == N_NEURONS-1`.
  - DONE → IDLE unconditionally after one cycle.
- `step_start` is ignored outside IDLE.
- Handshake: a transfer occurs when `in_valid && in_ready`. `in_ready` = (state == RUN). `idx` increments by 1 per transfer. `in_valid` gaps stall the sequence indefinitely.
- Update for neuron i on a transfer, with v = `mem[i]`:
  - Decay: d = (v>>>1) + (v>>>2), arithmetic shifts, 8-bit.
  - Integrate: s = d + `in_data`, computed in 9 bits, then saturated to [-128, 127].
  - If `refr[i]` ≠ 0: `mem[i]` ← 0, `refr[i]` ← `refr[i]`−1, spike = 0. The input is discarded.
  - Else if s ≥ `THRESHOLD` (signed compare): spike = 1, `mem[i]` ← s − `THRESHOLD`, `refr[i]` ← `REFRACT`.
  - Else: `mem[i]` ← s, spike = 0.
- Bit i of the spike accumulator is set to the spike result. `spk_vec` ← accumulator, with the final neuron's bit included, on the last transfer.
- `busy` = (state ≠ IDLE).

## Timing

- Reset values:
  - State IDLE, `idx` = 0.
  - `in_ready` = 0, `busy` = 0, `step_done` = 0, `spk_vec` = 0.
  - All `mem` = 0 and all `refr` = 0.
  - Reset takes effect immediately, asynchronously.
- `step_start` sampled high at edge e puts the block in RUN at e. `in_ready` = 1 and `busy` = 1 in the cycle following e.
- Each update completes at the edge of its handshake; this is single-cycle latency, with a throughput of one neuron per cycle.
- The final transfer at edge f updates `spk_vec` at f. `step_done` is high for exactly the cycle after f (DONE). `in_ready` is 0 in DONE.
- Minimum timestep length is N_NEURONS + 2 cycles from `step_start` to IDLE.
- `spk_vec` holds its value until the next final transfer and is never cleared between steps.
- A `step_start` pulse during RUN or DONE is dropped; it is not queued.
- Reset asserted mid-step aborts the step. All membrane and refractory state is cleared. `spk_vec` returns to 0 and no `step_done` is produced.
- `in_valid` asserted in IDLE or DONE has no effect on any state.

## Test plan

1. **Reset.** Assert `rst` mid-cycle → all outputs 0 immediately. After release, a step with all inputs 0 gives `spk_vec` = 0 and `step_done` is a one-cycle pulse exactly N+1 cycles after `step_start`, with `in_valid` held high.
2. **Integration to fire.** Drive neuron 0 with 40 each step and the others with 0 → `mem[0]` reads 40, 70, 92, then step 4 gives s = 109, `spk_vec[0]` = 1, `mem[0]` = 7.
3. **Refractory.** Continue test 2 with neuron 0 input 127 → steps 5 and 6 give no spike and `mem[0]` = 0. Step 7 gives s = 127, a spike, and `mem[0]` = 25.
4. **Negative saturation.** Drive neuron 3 with −128 for two steps → `mem[3]` = −128 after step 1. Step 2 computes −96 + −128 = −224, which saturates to −128. No spike.
5. **Backpressure and ignored start.** Apply random `in_valid` gaps and pulse `step_start` while `busy` → `idx` advances only on handshakes. The extra start is dropped, and results equal the gap-free run.
6. **Reset mid-step.** Assert `rst` after 3 transfers in step 4 of test 2 → `mem` and `refr` are cleared and `step_done` never fires. The next step restarts neuron 0 from `mem` = 0.
